// File: rtl/ysyx_24110015_fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ysyx_24110015_fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h3000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        fault;
  } fetch_pkt_t;

endpackage

// File: rtl/ysyx_24110015_fetch_outbuf.sv
// One-entry valid/ready register holding a fetch packet; flush drops the entry.
// Payload is held while valid and not ready; load takes precedence over a pop.
module ysyx_24110015_fetch_outbuf
  import ysyx_24110015_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  input  fetch_pkt_t in_pkt,
  output logic       out_valid,
  input  logic       out_ready,
  output fetch_pkt_t out_pkt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pkt   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      out_pkt   <= in_pkt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_24110015_fetch_ctrl.sv
// Fetch controller: owns the fetch PC, issues one imem request at a time,
// records the predicted next PC and hands instructions to decode; redirects on mispredict.
module ysyx_24110015_fetch_ctrl
  import ysyx_24110015_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] bp_pc_in,
  input  logic [31:0] bp_pc_predict,
  input  logic        bp_pc_predict_valid,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pred_pc,
  output logic        out_pred_taken,
  output logic        out_fault
);

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n, next_pc, next_pc_n;
  logic         pred_taken_q, pred_taken_n;
  logic         req_hs, load;
  fetch_pkt_t   load_pkt, out_pkt;
  logic         redirect_lsb_unused;

  assign bp_pc_in            = pc;
  assign imem_addr           = pc;
  assign imem_req_valid      = (state == REQ) && (!out_valid || out_ready);
  assign req_hs              = imem_req_valid && imem_req_ready;
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  always_comb begin
    load_pkt.inst       = imem_resp_err ? NOP_INST : imem_resp_data;
    load_pkt.pc         = pc;
    load_pkt.pred_pc    = next_pc;
    load_pkt.pred_taken = pred_taken_q;
    load_pkt.fault      = imem_resp_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= REQ;
      pc           <= RESET_PC;
      next_pc      <= RESET_PC;
      pred_taken_q <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      next_pc      <= next_pc_n;
      pred_taken_q <= pred_taken_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    next_pc_n    = next_pc;
    pred_taken_n = pred_taken_q;
    load         = 1'b0;

    case (state)
      REQ: begin
        if (req_hs) begin
          next_pc_n    = bp_pc_predict;
          pred_taken_n = bp_pc_predict_valid;
          state_n      = WAIT;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          load    = 1'b1;
          pc_n    = next_pc;
          state_n = imem_resp_err ? HALT : REQ;
        end
      end
      FLUSH: begin
        if (imem_resp_valid) state_n = REQ;
      end
      default: ;
    endcase

    // A redirect overrides everything; a request still in flight must be flushed.
    if (redirect_valid) begin
      load = 1'b0;
      pc_n = {redirect_pc[31:2], 2'b00};
      case (state)
        REQ:     state_n = req_hs ? FLUSH : REQ;
        WAIT:    state_n = imem_resp_valid ? REQ : FLUSH;
        FLUSH:   state_n = imem_resp_valid ? REQ : FLUSH;
        default: state_n = REQ;
      endcase
    end
  end

  ysyx_24110015_fetch_outbuf u_outbuf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .in_valid  (load),
    .in_pkt    (load_pkt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pkt   (out_pkt)
  );

  assign out_inst       = out_pkt.inst;
  assign out_pc         = out_pkt.pc;
  assign out_pred_pc    = out_pkt.pred_pc;
  assign out_pred_taken = out_pkt.pred_taken;
  assign out_fault      = out_pkt.fault;

endmodule

// File: tb/tb_ysyx_24110015_fetch_ctrl.sv
// Bench for the fetch controller: directed vector table, then random traffic vs a transaction model.
module tb_ysyx_24110015_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bp_pc_in, bp_pc_predict;
  logic        bp_pc_predict_valid;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid, imem_resp_err;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_inst, out_pc, out_pred_pc;
  logic        out_pred_taken, out_fault;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Predictor stand-in: BTB hit when pc[4:2]==3'b010, jumping to the next 256-byte block.
  function automatic logic pred_hit(input logic [31:0] pc);
    return pc[4:2] == 3'b010;
  endfunction
  function automatic logic [31:0] pred_target(input logic [31:0] pc);
    return pred_hit(pc) ? ((pc & ~32'hFF) + 32'h100) : (pc + 32'd4);
  endfunction

  assign bp_pc_predict       = pred_target(bp_pc_in);
  assign bp_pc_predict_valid = pred_hit(bp_pc_in);

  ysyx_24110015_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .bp_pc_in(bp_pc_in), .bp_pc_predict(bp_pc_predict), .bp_pc_predict_valid(bp_pc_predict_valid),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_pred_pc(out_pred_pc), .out_pred_taken(out_pred_taken), .out_fault(out_fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rdy, rv;
    logic [31:0] rdata;
    logic        rerr, redir;
    logic [31:0] rpc;
    logic        ordy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_inst, e_pc, e_ppc;
    logic        e_ptk, e_flt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rdy, input logic rv, input logic [31:0] rdata, input logic rerr,
                     input logic redir, input logic [31:0] rpc, input logic ordy,
                     input logic e_req, input logic [31:0] e_addr, input logic e_ov,
                     input logic [31:0] e_inst, input logic [31:0] e_pc, input logic [31:0] e_ppc,
                     input logic e_ptk, input logic e_flt);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.rerr = rerr; v.redir = redir; v.rpc = rpc;
    v.ordy = ordy; v.e_req = e_req; v.e_addr = e_addr; v.e_ov = e_ov; v.e_inst = e_inst;
    v.e_pc = e_pc; v.e_ppc = e_ppc; v.e_ptk = e_ptk; v.e_flt = e_flt;
    vecs.push_back(v);
  endtask

  task automatic chk_reset_values();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_pred_pc", out_pred_pc, 32'd0);
    chk("rst_out_flags", {30'd0, out_pred_taken, out_fault}, 32'd0);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rst_imem_addr", imem_addr, RST_PC);
  endtask

  // Transaction-level model state for the random phase.
  logic [31:0] m_pc;
  logic        m_halt, m_outst, m_disc, m_full;
  logic [31:0] m_o_pc, m_o_pred;
  logic        m_o_tk;
  logic [31:0] s_inst, s_pc, s_pred;
  logic        s_tk, s_flt;
  logic        mem_busy;
  logic [31:0] mem_addr;
  int          mem_due;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_halt = 1'b0; m_outst = 1'b0; m_disc = 1'b0; m_full = 1'b0;
    mem_busy = 1'b0;
  endtask

  initial begin
    logic exp_req, hs, err;
    int   cyc;
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0; imem_resp_err = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;

    // Directed rows: inputs for one cycle, expected outputs in that cycle.
    add(1,0,0,0,0,0,1, 1,32'h3000_0000,0, 0,0,0,0,0);
    add(1,1,32'h0000_0093,0,0,0,1, 0,32'h3000_0000,0, 0,0,0,0,0);
    add(1,0,0,0,0,0,1, 1,32'h3000_0004,1, 32'h0000_0093,32'h3000_0000,32'h3000_0004,0,0);
    add(1,1,32'h0010_0113,0,0,0,1, 0,32'h3000_0004,0, 0,0,0,0,0);
    add(1,0,0,0,0,0,1, 1,32'h3000_0008,1, 32'h0010_0113,32'h3000_0004,32'h3000_0008,0,0);
    add(1,1,32'h0020_0193,0,0,0,1, 0,32'h3000_0008,0, 0,0,0,0,0);
    for (int i = 0; i < 5; i++)
      add(1,0,0,0,0,0,0, 0,32'h3000_0100,1, 32'h0020_0193,32'h3000_0008,32'h3000_0100,1,0);
    add(1,0,0,0,0,0,1, 1,32'h3000_0100,1, 32'h0020_0193,32'h3000_0008,32'h3000_0100,1,0);
    add(1,0,0,0,1,32'h3000_0203,1, 0,32'h3000_0100,0, 0,0,0,0,0);
    add(1,1,32'hDEAD_BEEF,0,0,0,1, 0,32'h3000_0200,0, 0,0,0,0,0);
    add(1,0,0,0,0,0,1, 1,32'h3000_0200,0, 0,0,0,0,0);
    add(1,1,32'h0000_0513,0,0,0,1, 0,32'h3000_0200,0, 0,0,0,0,0);
    add(1,0,0,0,1,32'h3000_0010,1, 1,32'h3000_0204,1, 32'h0000_0513,32'h3000_0200,32'h3000_0204,0,0);
    add(1,1,32'hBADB_AD00,0,0,0,1, 0,32'h3000_0010,0, 0,0,0,0,0);
    add(1,0,0,0,0,0,1, 1,32'h3000_0010,0, 0,0,0,0,0);
    add(1,1,32'h1234_5678,1,0,0,1, 0,32'h3000_0010,0, 0,0,0,0,0);
    add(1,0,0,0,0,0,1, 0,32'h3000_0014,1, 32'h0000_0013,32'h3000_0010,32'h3000_0014,0,1);
    for (int i = 0; i < 19; i++)
      add(1,0,0,0,0,0,1, 0,32'h3000_0014,0, 0,0,0,0,0);
    add(1,0,0,0,1,32'h3000_0000,1, 0,32'h3000_0014,0, 0,0,0,0,0);
    add(1,0,0,0,0,0,1, 1,32'h3000_0000,0, 0,0,0,0,0);
    add(1,1,32'h1111_1111,0,1,32'h3000_0040,1, 0,32'h3000_0000,0, 0,0,0,0,0);
    add(0,0,0,0,0,0,1, 1,32'h3000_0040,0, 0,0,0,0,0);
    add(1,0,0,0,0,0,1, 1,32'h3000_0040,0, 0,0,0,0,0);
    add(1,1,32'h2222_2222,0,0,0,1, 0,32'h3000_0040,0, 0,0,0,0,0);
    add(1,0,0,0,0,0,1, 1,32'h3000_0044,1, 32'h2222_2222,32'h3000_0040,32'h3000_0044,0,0);

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_reset_values();

    foreach (vecs[i]) begin
      @(negedge clk);
      imem_req_ready = vecs[i].rdy; imem_resp_valid = vecs[i].rv; imem_resp_data = vecs[i].rdata;
      imem_resp_err = vecs[i].rerr; redirect_valid = vecs[i].redir; redirect_pc = vecs[i].rpc;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, vecs[i].e_req});
      chk($sformatf("vec%0d_imem_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      if (vecs[i].e_ov) begin
        chk($sformatf("vec%0d_out_inst", i), out_inst, vecs[i].e_inst);
        chk($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].e_pc);
        chk($sformatf("vec%0d_out_pred_pc", i), out_pred_pc, vecs[i].e_ppc);
        chk($sformatf("vec%0d_out_flags", i), {30'd0, out_pred_taken, out_fault},
            {30'd0, vecs[i].e_ptk, vecs[i].e_flt});
      end
    end

    // The last row issued a request; reset asynchronously while it is outstanding.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    #1 rst = 1'b0;
    #0 chk_reset_values();
    imem_resp_valid = 1'b0; redirect_valid = 1'b0;
    model_reset();

    cyc = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      out_ready      = ($urandom % 4) != 0;
      imem_req_ready = ($urandom % 4) != 0;
      if (mem_busy && cyc == mem_due) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = inst_of(mem_addr);
        imem_resp_err   = ($urandom % 24) == 0;
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        imem_resp_err   = 1'b0;
      end
      redirect_valid = m_halt ? (($urandom % 3) == 0) : (($urandom % 16) == 0);
      redirect_pc    = RST_PC + 32'($urandom_range(0, 4095));
      #1;

      exp_req = !m_halt && !m_outst && (!m_full || out_ready);
      chk("rnd_req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req});
      chk("rnd_out_valid", {31'd0, out_valid}, {31'd0, m_full});
      if (exp_req) chk("rnd_imem_addr", imem_addr, m_pc);
      if (m_full) begin
        chk("rnd_out_inst", out_inst, s_inst);
        chk("rnd_out_pc", out_pc, s_pc);
        chk("rnd_out_pred_pc", out_pred_pc, s_pred);
        chk("rnd_out_flags", {30'd0, out_pred_taken, out_fault}, {30'd0, s_tk, s_flt});
      end

      hs  = exp_req && imem_req_ready;
      err = imem_resp_err;
      if (m_full && out_ready) m_full = 1'b0;
      if (imem_resp_valid) begin
        if (!m_disc && !redirect_valid) begin
          m_full = 1'b1;
          s_inst = err ? 32'h0000_0013 : imem_resp_data;
          s_pc = m_o_pc; s_pred = m_o_pred; s_tk = m_o_tk; s_flt = err;
          m_pc = m_o_pred;
          m_halt = err;
        end
        m_outst = 1'b0;
        mem_busy = 1'b0;
      end
      if (hs) begin
        m_outst = 1'b1; m_disc = 1'b0;
        m_o_pc = m_pc; m_o_pred = pred_target(m_pc); m_o_tk = pred_hit(m_pc);
        mem_busy = 1'b1; mem_addr = m_pc; mem_due = cyc + int'($urandom_range(1, 3));
      end
      if (redirect_valid) begin
        m_pc = {redirect_pc[31:2], 2'b00};
        m_full = 1'b0;
        m_halt = 1'b0;
        if (m_outst) m_disc = 1'b1;
      end
      cyc++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
